// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared types, constants and helpers for the CRC-32 arbiter
package crc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } crc_arb_state_e;

   localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
   localparam int          RR_MAX       = 16;

   function automatic logic [7:0] rev8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction

   function automatic logic [31:0] rev32(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = d[31-i];
      return r;
   endfunction

   // First set valid bit searching upward from ptr+1, wrapping modulo n.
   function automatic int rr_pick(input logic [RR_MAX-1:0] valid, input int ptr, input int n);
      int  pick;
      int  idx;
      bit  found;
      pick  = 0;
      found = 1'b0;
      for (int i = 1; i <= RR_MAX; i++) begin
         if (!found && i <= n) begin
            idx = (ptr + i) % n;
            if (valid[idx]) begin
               pick  = idx;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/crc32_04c11db7.sv
// rtl/crc32_04c11db7.sv - one-byte MSB-first CRC-32 step, polynomial 0x04C11DB7
module crc32_04c11db7
   import crc_pkg::*;
(
   input  logic [7:0]  data_i,
   input  logic [31:0] crc_i,
   output logic [31:0] crc_o
);

   function automatic logic [31:0] step8(input logic [7:0] d, input logic [31:0] c_in);
      logic [31:0] c;
      c = c_in;
      for (int i = 7; i >= 0; i--) begin
         c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? CRC32_POLY : 32'h0);
      end
      return c;
   endfunction

   assign crc_o = step8(data_i, crc_i);

endmodule

// File: rtl/crc32_arbiter.sv
// rtl/crc32_arbiter.sv - round-robin, frame-locked sharing of one CRC-32 byte engine
module crc32_arbiter
   import crc_pkg::*;
#(
   parameter int          NUM_REQ = 4,
   parameter bit          REFIN   = 1'b1,
   parameter bit          REFOUT  = 1'b1,
   parameter logic [31:0] INIT    = CRC32_INIT,
   parameter logic [31:0] XOROUT  = CRC32_XOROUT,
   localparam int         IW      = $clog2(NUM_REQ)
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   input  logic [8*NUM_REQ-1:0]   req_data_i,
   input  logic [NUM_REQ-1:0]     req_last_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   output logic                   res_valid_o,
   input  logic                   res_ready_i,
   output logic [31:0]            res_crc_o,
   output logic [IW-1:0]          res_id_o,
   output logic                   busy_o
);

   crc_arb_state_e r_state;
   logic [31:0]    r_crc;
   logic [IW-1:0]  r_gnt;
   logic [IW-1:0]  r_ptr;

   int             w_pick;
   logic [7:0]     w_byte;
   logic [7:0]     w_step_in;
   logic [31:0]    w_crc_next;
   logic           w_accept;
   logic           w_last;

   assign w_pick    = rr_pick(RR_MAX'(req_valid_i), int'(r_ptr), NUM_REQ);
   assign w_byte    = req_data_i[8*r_gnt +: 8];
   assign w_step_in = REFIN ? rev8(w_byte) : w_byte;
   assign w_last    = req_last_i[r_gnt];
   assign w_accept  = (r_state == ST_RUN) && req_valid_i[r_gnt];

   crc32_04c11db7 u_step (
      .data_i (w_step_in),
      .crc_i  (r_crc),
      .crc_o  (w_crc_next)
   );

   // Grant is locked from arbitration until the frame's last byte; ptr moves only then.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
         r_crc   <= INIT;
         r_ptr   <= IW'(NUM_REQ - 1);
         r_gnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req_valid_i) begin
                  r_gnt   <= IW'(w_pick);
                  r_crc   <= INIT;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_accept) begin
                  r_crc <= w_crc_next;
                  if (w_last) begin
                     r_ptr   <= r_gnt;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (res_ready_i) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (r_state == ST_RUN) req_ready_o[r_gnt] = 1'b1;
   end

   assign res_valid_o = (r_state == ST_DONE);
   assign res_crc_o   = res_valid_o ? ((REFOUT ? rev32(r_crc) : r_crc) ^ XOROUT) : 32'h0;
   assign res_id_o    = res_valid_o ? r_gnt : '0;
   assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: doc/crc32_arbiter.md
# crc32_arbiter

Time-shared CRC-32 engine controller. It lets `NUM_REQ` byte-stream requesters share one instance of the byte-step CRC function `crc32_04c11db7` (polynomial 0x04C11DB7). Arbitration is round-robin and a grant is held for a whole frame. The block applies init, input/output reflection and final XOR, then returns the tagged result on a valid/ready result port. It sits between DMA/packet producers and the register-mapped CRC result logic.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `REFIN`, 1: bit-reverse each input byte before the CRC step.
- `REFOUT`, 1: bit-reverse the 32-bit CRC before the final XOR.
- `INIT`, 32'hFFFF_FFFF: CRC register value at frame start.
- `XOROUT`, 32'hFFFF_FFFF: final XOR mask.

Ports (`IW = $clog2(NUM_REQ)`):
- `clk_i`, in, 1: single clock; all logic is rising-edge.
- `rst_n_i`, in, 1: asynchronous, active-low reset.
- `req_valid_i`, in, NUM_REQ: per-requester byte valid.
- `req_data_i`, in, 8*NUM_REQ: byte k is at bits [8k+7:8k].
- `req_last_i`, in, NUM_REQ: the byte is the last of its frame.
- `req_ready_o`, out, NUM_REQ: byte accepted when valid&ready.
- `res_valid_o`, out, 1: result available.
- `res_ready_i`, in, 1: result consumer ready.
- `res_crc_o`, out, 32: final CRC.
- `res_id_o`, out, IW: requester index that owns the result.
- `busy_o`, out, 1: high in any state other than IDLE.

## Operation
- FSM with three states: IDLE, RUN, DONE.
- **IDLE**
  - All `req_ready_o` = 0.
  - If any `req_valid_i` is set, pick the first set index searching from `ptr+1`, with modulo-NUM_REQ wrap.
  - Register it as `gnt`, load `crc <= INIT`, and go to RUN.
- **RUN**
  - `req_ready_o[gnt]` = 1; all other ready bits = 0.
  - On each accepted byte: `crc <= step(REFIN ? rev8(data) : data, crc)`.
  - If `req_last_i[gnt]` is set on the accepted byte, go to DONE and set `ptr <= gnt`.
  - If `req_valid_i[gnt]` drops, the block stalls with no timeout, and the grant stays locked.
- **DONE**
  - `res_valid_o` = 1.
  - `res_crc_o = (REFOUT ? rev32(crc) : crc) ^ XOROUT`.
  - `res_id_o` = `gnt`.
  - All ready bits = 0.
  - On `res_ready_i`, go to IDLE.
- Other requesters' `valid`, `data` and `last` are ignored while they are not granted.
- There are no zero-length frames: `last` always travels with a data byte.
- **Reset**, asserted at any time: the frame in progress is discarded and no result is produced. Reset values:
  - state = IDLE, `crc` = INIT, `ptr` = NUM_REQ-1 so requester 0 has first priority, `gnt` = 0.
  - All outputs 0: `req_ready_o`, `res_valid_o`, `res_crc_o`, `res_id_o`, `busy_o`.

## Timing
- Arbitration latency: a valid seen in IDLE in cycle t gives ready in cycle t+1.
- Throughput: 1 byte/cycle in RUN.
- Result latency: last byte accepted in cycle t gives `res_valid_o` in cycle t+1.
- Minimum frame turnaround: N bytes + 1 (IDLE) + 1 (DONE, if `res_ready_i` is already high) cycles. Back-to-back frames therefore have a 2-cycle bubble.
- `res_crc_o` and `res_id_o` hold stable while `res_valid_o` is high and `res_ready_i` is low.
- `ptr` updates only on frame completion, so each requester waits at most NUM_REQ-1 frames.
- `req_ready_o` and `res_valid_o` are functions of registered state only; they have no combinational path from inputs.

## Structure
- Package `crc_pkg` contains:
  - the state enum `crc_arb_state_e`;
  - the constants `CRC32_INIT` and `CRC32_XOROUT` (both 32'hFFFF_FFFF);
  - the functions `rev8` and `rev32`.
- One sub-module: a single instance of `crc32_04c11db7`. Its `data_i` is the muxed, optionally reflected granted byte; its `crc_i` is the `crc` register.
- Round-robin selection is an inline function in the package, `rr_pick(valid, ptr)`.

## Test plan
- Defaults; requester 0 sends ASCII "123456789" with `last` on '9' → one result, `res_crc_o` = 32'hCBF43926, `res_id_o` = 0, 9 accept cycles.
- Single byte 0x00 from requester 2 → 32'hD202EF8D, `res_id_o` = 2. Then single byte 0x61 → 32'hE8B7BE43.
- `REFIN`=0, `REFOUT`=0, `XOROUT`=0, "123456789" → 32'h0376E6E7. With `XOROUT`=32'hFFFFFFFF → 32'hFC891918.
- All 4 requesters valid continuously with 2-byte frames → grant order 0,1,2,3,0,…; no byte accepted from a non-granted requester; each CRC is correct.
- `res_ready_i` held low for 5 cycles → `res_valid_o`, `res_crc_o` and `res_id_o` are stable; all ready bits stay 0. Granted requester's `valid` gaps mid-frame → CRC is unchanged versus the gap-free run.
- `rst_n_i` asserted after 4 of 9 bytes → outputs 0 immediately. After release, no stale result is produced, and a fresh "123456789" gives 32'hCBF43926.
